// File: rtl/alu_seq_pkg.sv
// +----------------------------------------------------------------------+
// | alu_seq_pkg : shared opcodes, bus request codes and FSM states for    |
// |               the sequential immediate-ALU coprocessor.               |
// | Revision    : 1.0                                                     |
// +----------------------------------------------------------------------+
`default_nettype none

package alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_ADDI = 4'd1,
    OP_SUBI = 4'd2,
    OP_ANDI = 4'd3,
    OP_ORI  = 4'd4,
    OP_XORI = 4'd5,
    OP_SHLI = 4'd6,
    OP_SHRI = 4'd7
  } opcode_e;

  localparam logic [3:0] BUS_REQ_IDLE = 4'b0000;
  localparam logic [3:0] BUS_REQ_ADDR = 4'b0011;
  localparam logic [3:0] BUS_REQ_DATA = 4'b0001;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_FETCH = 3'd2,
    S_EXEC  = 3'd3,
    S_WRITE = 3'd4
  } state_e;

  // Opcodes that need an operand fetch; everything else completes in IDLE.
  function automatic logic op_is_alu(input logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd7);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_seq_exec.sv
// +----------------------------------------------------------------------+
// | alu_seq_exec : combinational datapath, op/A/B -> {carry, result}.     |
// | Revision     : 1.0                                                    |
// +----------------------------------------------------------------------+
`default_nettype none

module alu_seq_exec
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  logic [3:0]        op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W:0]   res_o
);

  localparam int K = $clog2(DATA_W);

  logic [K-1:0]    amt;
  logic [DATA_W:0] shr_ext;

  assign amt = a_i[K-1:0];

  always_comb begin
    res_o   = '0;
    shr_ext = '0;
    case (op_i)
      OP_ADDI: res_o = {1'b0, a_i} + {1'b0, b_i};
      OP_SUBI: res_o = {1'b0, a_i} - {1'b0, b_i};
      OP_ANDI: res_o = {1'b0, a_i & b_i};
      OP_ORI:  res_o = {1'b0, a_i | b_i};
      OP_XORI: res_o = {1'b0, a_i ^ b_i};
      OP_SHLI: res_o = {1'b0, b_i} << amt;
      OP_SHRI: begin
        // A guard bit below the LSB catches the last bit shifted out.
        shr_ext = {b_i, 1'b0} >> amt;
        res_o   = {shr_ext[0], shr_ext[DATA_W:1]};
      end
      default: res_o = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/alu_seq_core.sv
// +----------------------------------------------------------------------+
// | alu_seq_core : sequential immediate-ALU coprocessor; fetches operand |
// |                B over the shared bus, computes, writes result back.  |
// | Revision     : 1.0                                                    |
// +----------------------------------------------------------------------+
`default_nettype none

module alu_seq_core
  import alu_seq_pkg::*;
#(
  parameter int DATA_W  = 4,
  parameter int TIMEOUT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [3:0]        op_i,
  input  logic [DATA_W-1:0] imm_i,
  output logic [3:0]        bus_req_o,
  input  logic [DATA_W-1:0] bus_i,
  input  logic              ready_i,
  input  logic              oe_n_i,
  output logic [DATA_W-1:0] bus_o,
  output logic [DATA_W-1:0] bus_oe_o,
  output logic              carry_o,
  output logic              zero_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e            state_q;
  logic [3:0]        op_q;
  logic [DATA_W-1:0] imm_q;
  logic [DATA_W-1:0] opb_q;
  logic [DATA_W:0]   res_q;
  logic [DATA_W:0]   res_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [3:0]        bus_req_q;
  logic [DATA_W-1:0] bus_q;
  logic [DATA_W-1:0] oe_q;
  logic              carry_q;
  logic              zero_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic              timeout_hit;

  alu_seq_exec #(.DATA_W(DATA_W)) u_exec (
    .op_i  (op_q),
    .a_i   (imm_q),
    .b_i   (opb_q),
    .res_o (res_d)
  );

  assign timeout_hit = (TIMEOUT > 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      imm_q     <= '0;
      opb_q     <= '0;
      res_q     <= '0;
      cnt_q     <= '0;
      bus_req_q <= BUS_REQ_IDLE;
      bus_q     <= '0;
      oe_q      <= '0;
      carry_q   <= 1'b0;
      zero_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          bus_q <= '0;
          oe_q  <= '0;
          if (start_i) begin
            op_q  <= op_i;
            imm_q <= imm_i;
            err_q <= 1'b0;
            if (op_is_alu(op_i)) begin
              state_q   <= S_REQ;
              busy_q    <= 1'b1;
              bus_req_q <= BUS_REQ_ADDR;
            end else begin
              done_q <= 1'b1;
              err_q  <= (op_i != OP_NOP);
            end
          end
        end
        S_REQ: begin
          state_q   <= S_FETCH;
          bus_req_q <= BUS_REQ_DATA;
          cnt_q     <= '0;
        end
        S_FETCH: begin
          // ready_i takes priority over a timeout expiring on the same edge.
          if (ready_i) begin
            opb_q     <= bus_i;
            state_q   <= S_EXEC;
            bus_req_q <= BUS_REQ_IDLE;
          end else if (timeout_hit) begin
            err_q     <= 1'b1;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            bus_req_q <= BUS_REQ_IDLE;
            state_q   <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_EXEC: begin
          res_q   <= res_d;
          carry_q <= res_d[DATA_W];
          zero_q  <= (res_d[DATA_W-1:0] == '0);
          state_q <= S_WRITE;
        end
        S_WRITE: begin
          if (!oe_n_i) begin
            bus_q   <= res_q[DATA_W-1:0];
            oe_q    <= '1;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          busy_q    <= 1'b0;
          bus_req_q <= BUS_REQ_IDLE;
        end
      endcase
    end
  end

  assign bus_req_o = bus_req_q;
  assign bus_o     = bus_q;
  assign bus_oe_o  = oe_q;
  assign carry_o   = carry_q;
  assign zero_o    = zero_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign err_o     = err_q;

endmodule

`default_nettype wire
